// File: rtl/mont_res_final_sub_pkg.sv
// mont_res_final_sub_pkg
// Definitions shared by the final-subtraction stage and the Montgomery
// multiplier that feeds it:
//   - state_t            : sequencer state encoding
//   - calc_width         : digit count rounded up to an even number
//   - calc_res_mem_depth : packed result memory entries (two digits per entry)
//   - digit_in_hi        : digit-unpack convention for a packed result entry
package mont_res_final_sub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SUB  = 2'd1,
      ST_SEL  = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   function automatic int calc_width(input int width_real);
      return ((width_real + 1) / 2) * 2;
   endfunction

   function automatic int calc_res_mem_depth(input int width_real);
      return calc_width(width_real) / 2;
   endfunction

   // Even digits live in the upper half of an entry, odd digits in the lower half.
   function automatic logic digit_in_hi(input logic k_lsb);
      return ~k_lsb;
   endfunction

endpackage

// File: rtl/mont_digit_sub.sv
// mont_digit_sub
// Registered (RADIX+1)-bit digit slice. Computes a - b - cin (borrow chain)
// or, with op_add, a + b + cin (carry chain). The registered cout is meant to
// be fed straight back into cin for digit-serial operation.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : clears the borrow/carry ahead of a new operand
//   en       : register a new digit result
//   op_add   : 0 = subtract, 1 = add
//   a, b     : operand digits
//   cin      : borrow/carry in
//   d        : registered result digit
//   cout     : registered borrow/carry out
module mont_digit_sub #(
   parameter int RADIX = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             op_add,
   input  logic [RADIX-1:0] a,
   input  logic [RADIX-1:0] b,
   input  logic             cin,
   output logic [RADIX-1:0] d,
   output logic             cout
);

   logic [RADIX:0] res;

   // Bit RADIX of the extended result is the carry (add) or borrow (subtract).
   always_comb begin
      res = '0;
      if (op_add) begin
         res = {1'b0, a} + {1'b0, b} + {{RADIX{1'b0}}, cin};
      end else begin
         res = {1'b0, a} - {1'b0, b} - {{RADIX{1'b0}}, cin};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         d    <= '0;
         cout <= 1'b0;
      end else if (clr) begin
         cout <= 1'b0;
      end else if (en) begin
         {cout, d} <= res;
      end
   end

endmodule

// File: rtl/single_port_mem.sv
// single_port_mem
// Single-port synchronous RAM with a one-cycle read latency.
// Ports:
//   clk  : clock
//   en   : port enable (read or write)
//   we   : write enable (valid with en)
//   addr : word address
//   din  : write data
//   dout : read data, valid the cycle after an enabled read
module single_port_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= din;
         end else begin
            dout <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/mont_res_final_sub.sv
// mont_res_final_sub
// Final conditional subtraction after the pipelined Montgomery multiplier.
// Reads t (< 2p) from the packed result memory and writes t - p when t >= p,
// otherwise t, one digit per cycle (least significant digit first).
// Pass 1 (SUB) runs the borrow chain into a local scratch buffer; pass 2
// (SEL) re-reads t and picks scratch or t by the final borrow.
// done follows start by exactly 2*WIDTH_REAL+5 cycles.
//
// Optional build macro: MONT_NEG_CORRECTION_EN adds input neg_fix, sampled on
// start; when set, pass 1 computes t + p instead and pass 2 always outputs
// scratch (ge_p forced to 1).
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : one-cycle pulse, honoured only in IDLE
//   busy, done        : operation in progress / one-cycle completion pulse
//   res_rd_en/addr    : result memory read port (entry = {t[2i], t[2i+1]})
//   res_dout          : result memory data, 1-cycle latency
//   p_rd_en/addr      : modulus memory read port (one digit per address)
//   p_dout            : modulus digit, 1-cycle latency
//   out_wr_en/addr/din: output digit write port
//   ge_p              : t >= p, valid from done until the next start
//
// state | meaning
// IDLE  | waiting for start, read ports quiet
// SUB   | issue reads for digits 0..W-1, run borrow chain into scratch
// SEL   | re-read t and scratch, write selected digits to the output
// FIN   | one-cycle done pulse
module mont_res_final_sub
   import mont_res_final_sub_pkg::*;
#(
   parameter int RADIX             = 24,
   parameter int WIDTH_REAL        = 32,
   parameter int WIDTH             = calc_width(WIDTH_REAL),
   parameter int RES_MEM_DEPTH     = WIDTH / 2,
   parameter int RES_MEM_DEPTH_LOG = $clog2(RES_MEM_DEPTH),
   parameter int DIGIT_LOG         = $clog2(WIDTH_REAL)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
`ifdef MONT_NEG_CORRECTION_EN
   input  logic                         neg_fix,
`endif
   output logic                         busy,
   output logic                         done,
   output logic                         res_rd_en,
   output logic [RES_MEM_DEPTH_LOG-1:0] res_rd_addr,
   input  logic [2*RADIX-1:0]           res_dout,
   output logic                         p_rd_en,
   output logic [DIGIT_LOG-1:0]         p_rd_addr,
   input  logic [RADIX-1:0]             p_dout,
   output logic                         out_wr_en,
   output logic [DIGIT_LOG-1:0]         out_wr_addr,
   output logic [RADIX-1:0]             out_din,
   output logic                         ge_p
);

   // k must be able to hold WIDTH_REAL itself to mark the end of issue.
   localparam int                   KW     = DIGIT_LOG + 1;
   localparam logic [KW-1:0]        K_END  = KW'(WIDTH_REAL);
   localparam logic [DIGIT_LOG-1:0] D_LAST = DIGIT_LOG'(WIDTH_REAL - 1);

   state_t               state;
   logic [KW-1:0]        k;
   logic                 d1_vld;
   logic [DIGIT_LOG-1:0] d1_k;
   logic [RADIX-1:0]     ent_lo;
   logic                 d2_vld;
   logic [DIGIT_LOG-1:0] d2_k;
   logic                 neg_q;

   logic                 iss;
   logic                 iss_even;
   logic                 start_go;
   logic                 neg_fix_in;
   logic [RADIX-1:0]     t_digit;
   logic [RADIX-1:0]     slice_d;
   logic                 slice_c;
   logic                 scr_en;
   logic                 scr_we;
   logic [DIGIT_LOG-1:0] scr_addr;
   logic [RADIX-1:0]     scr_dout;

`ifdef MONT_NEG_CORRECTION_EN
   assign neg_fix_in = neg_fix;
`else
   assign neg_fix_in = 1'b0;
`endif

   assign start_go = (state == ST_IDLE) && start;
   assign iss      = ((state == ST_SUB) || (state == ST_SEL)) && (k < K_END);
   assign iss_even = iss && digit_in_hi(k[0]);

   // Addresses are forced to zero when idle so the shared ports see no activity.
   assign res_rd_en   = iss_even;
   assign res_rd_addr = iss_even ? RES_MEM_DEPTH_LOG'(k >> 1) : '0;
   assign p_rd_en     = iss && (state == ST_SUB);
   assign p_rd_addr   = p_rd_en ? k[DIGIT_LOG-1:0] : '0;

   // Even digits come straight from the memory; odd digits from the entry
   // captured one cycle earlier. The padding half of an odd-sized last
   // entry is captured but never selected.
   assign t_digit = digit_in_hi(d1_k[0]) ? res_dout[2*RADIX-1:RADIX] : ent_lo;

   // Scratch writes (SUB drain) and reads (SEL issue) never share a cycle.
   assign scr_we   = (state == ST_SUB) && d2_vld;
   assign scr_en   = scr_we || ((state == ST_SEL) && iss);
   assign scr_addr = scr_we ? d2_k : k[DIGIT_LOG-1:0];

   mont_digit_sub #(
      .RADIX (RADIX)
   ) u_digit (
      .clk    (clk),
      .rst    (rst),
      .clr    (start_go),
      .en     (d1_vld && (state == ST_SUB)),
      .op_add (neg_q),
      .a      (t_digit),
      .b      (p_dout),
      .cin    (slice_c),
      .d      (slice_d),
      .cout   (slice_c)
   );

   single_port_mem #(
      .DATA_W (RADIX),
      .DEPTH  (WIDTH_REAL),
      .ADDR_W (DIGIT_LOG)
   ) u_scratch (
      .clk  (clk),
      .en   (scr_en),
      .we   (scr_we),
      .addr (scr_addr),
      .din  (slice_d),
      .dout (scr_dout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         k           <= '0;
         d1_vld      <= 1'b0;
         d1_k        <= '0;
         ent_lo      <= '0;
         d2_vld      <= 1'b0;
         d2_k        <= '0;
         neg_q       <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         ge_p        <= 1'b0;
         out_wr_en   <= 1'b0;
         out_wr_addr <= '0;
         out_din     <= '0;
      end else begin
         done      <= 1'b0;
         out_wr_en <= 1'b0;

         d1_vld <= iss;
         d1_k   <= k[DIGIT_LOG-1:0];
         d2_vld <= d1_vld && (state == ST_SUB);
         d2_k   <= d1_k;

         if (d1_vld && digit_in_hi(d1_k[0])) begin
            ent_lo <= res_dout[RADIX-1:0];
         end

         if (iss) begin
            k <= k + 1'b1;
         end

         if (d1_vld && (state == ST_SEL)) begin
            out_wr_en   <= 1'b1;
            out_wr_addr <= d1_k;
            out_din     <= ge_p ? scr_dout : t_digit;
         end

         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_SUB;
                  k     <= '0;
                  busy  <= 1'b1;
                  ge_p  <= 1'b0;
                  neg_q <= neg_fix_in;
               end
            end
            ST_SUB: begin
               // Last digit's borrow is registered in the slice this cycle.
               if (d2_vld && (d2_k == D_LAST)) begin
                  state <= ST_SEL;
                  k     <= '0;
                  ge_p  <= neg_q | ~slice_c;
               end
            end
            ST_SEL: begin
               if (out_wr_en && (out_wr_addr == D_LAST)) begin
                  state <= ST_FIN;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            ST_FIN: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mont_res_final_sub.sv
// tb_mont_res_final_sub
// Directed bench for mont_res_final_sub with RADIX=8: one instance with
// WIDTH_REAL=3 (odd, padded last entry) and one with WIDTH_REAL=4.
// Build with MONT_NEG_CORRECTION_EN defined to add the neg_fix scenario.
module tb_mont_res_final_sub;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // WIDTH_REAL = 3 instance
   logic        start3, busy3, done3, res_rd_en3, p_rd_en3, out_wr_en3, ge_p3;
   logic [0:0]  res_rd_addr3;
   logic [15:0] res_dout3;
   logic [1:0]  p_rd_addr3, out_wr_addr3;
   logic [7:0]  p_dout3, out_din3;
   logic [15:0] res_mem3 [2];
   logic [7:0]  p_mem3 [3];

   // WIDTH_REAL = 4 instance
   logic        start4, busy4, done4, res_rd_en4, p_rd_en4, out_wr_en4, ge_p4;
   logic [0:0]  res_rd_addr4;
   logic [15:0] res_dout4;
   logic [1:0]  p_rd_addr4, out_wr_addr4;
   logic [7:0]  p_dout4, out_din4;
   logic [15:0] res_mem4 [2];
   logic [7:0]  p_mem4 [4];

`ifdef MONT_NEG_CORRECTION_EN
   logic neg_fix3, neg_fix4;
`endif

   mont_res_final_sub #(.RADIX(8), .WIDTH_REAL(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3),
`ifdef MONT_NEG_CORRECTION_EN
      .neg_fix(neg_fix3),
`endif
      .busy(busy3), .done(done3),
      .res_rd_en(res_rd_en3), .res_rd_addr(res_rd_addr3), .res_dout(res_dout3),
      .p_rd_en(p_rd_en3), .p_rd_addr(p_rd_addr3), .p_dout(p_dout3),
      .out_wr_en(out_wr_en3), .out_wr_addr(out_wr_addr3), .out_din(out_din3),
      .ge_p(ge_p3)
   );

   mont_res_final_sub #(.RADIX(8), .WIDTH_REAL(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4),
`ifdef MONT_NEG_CORRECTION_EN
      .neg_fix(neg_fix4),
`endif
      .busy(busy4), .done(done4),
      .res_rd_en(res_rd_en4), .res_rd_addr(res_rd_addr4), .res_dout(res_dout4),
      .p_rd_en(p_rd_en4), .p_rd_addr(p_rd_addr4), .p_dout(p_dout4),
      .out_wr_en(out_wr_en4), .out_wr_addr(out_wr_addr4), .out_din(out_din4),
      .ge_p(ge_p4)
   );

   always @(posedge clk) begin
      if (res_rd_en3) res_dout3 <= res_mem3[res_rd_addr3];
      if (p_rd_en3)   p_dout3   <= p_mem3[p_rd_addr3];
      if (res_rd_en4) res_dout4 <= res_mem4[res_rd_addr4];
      if (p_rd_en4)   p_dout4   <= p_mem4[p_rd_addr4];
   end

   // Per-run observations, filled by run3/run4
   logic [7:0] out3 [4];
   logic [7:0] out4 [4];
   int wr_cnt, prd_cnt, rrd_cnt, last_wr;
   bit gap, busy_low;

   task automatic load3(input logic [23:0] t, input logic [7:0] pad);
      res_mem3[0] = {t[7:0], t[15:8]};
      res_mem3[1] = {t[23:16], pad};
      p_mem3[0] = 8'hFF; p_mem3[1] = 8'hFF; p_mem3[2] = 8'h7F;
   endtask

   task automatic load4(input logic [31:0] t, input logic [31:0] p);
      res_mem4[0] = {t[7:0], t[15:8]};
      res_mem4[1] = {t[23:16], t[31:24]};
      p_mem4[0] = p[7:0]; p_mem4[1] = p[15:8]; p_mem4[2] = p[23:16]; p_mem4[3] = p[31:24];
   endtask

   task automatic clear_obs();
      wr_cnt = 0; prd_cnt = 0; rrd_cnt = 0; last_wr = -1; gap = 0; busy_low = 0;
      for (int i = 0; i < 4; i++) begin out3[i] = 8'h5A; out4[i] = 8'h5A; end
   endtask

   // Pulses start and observes every cycle up to done; lat = cycle of done
   // counted from the start cycle, or -1 if done never came.
   task automatic run3(output int lat);
      int n;
      clear_obs();
      @(negedge clk); start3 = 1'b1;
      @(negedge clk); start3 = 1'b0; n = 1;
      while (1) begin
         if (out_wr_en3) begin
            out3[out_wr_addr3] = out_din3;
            if (last_wr >= 0 && n != last_wr + 1) gap = 1;
            last_wr = n; wr_cnt++;
         end
         if (p_rd_en3) prd_cnt++;
         if (res_rd_en3) rrd_cnt++;
         if (!busy3 && !done3) busy_low = 1;
         if (done3 || n >= 60) break;
         @(negedge clk); n++;
      end
      lat = done3 ? n : -1;
   endtask

   task automatic run4(output int lat);
      int n;
      clear_obs();
      @(negedge clk); start4 = 1'b1;
      @(negedge clk); start4 = 1'b0; n = 1;
      while (1) begin
         if (out_wr_en4) begin
            out4[out_wr_addr4] = out_din4;
            if (last_wr >= 0 && n != last_wr + 1) gap = 1;
            last_wr = n; wr_cnt++;
         end
         if (p_rd_en4) prd_cnt++;
         if (res_rd_en4) rrd_cnt++;
         if (!busy4 && !done4) busy_low = 1;
         if (done4 || n >= 60) break;
         @(negedge clk); n++;
      end
      lat = done4 ? n : -1;
   endtask

   task automatic test_reset();
      logic [31:0] obs3, obs4;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      obs3 = {busy3, done3, res_rd_en3, p_rd_en3, out_wr_en3, ge_p3,
              res_rd_addr3, p_rd_addr3, out_wr_addr3, out_din3, 13'd0};
      obs4 = {busy4, done4, res_rd_en4, p_rd_en4, out_wr_en4, ge_p4,
              res_rd_addr4, p_rd_addr4, out_wr_addr4, out_din4, 13'd0};
      checks++; if (obs3 !== 32'd0) begin errors++; $display("FAIL reset_outputs_w3 got %h exp 0", obs3); end
      checks++; if (obs4 !== 32'd0) begin errors++; $display("FAIL reset_outputs_w4 got %h exp 0", obs4); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_t_ge_p();
      int lat;
      load3(24'h800000, 8'h00);
      run3(lat);
      checks++; if (lat !== 11) begin errors++; $display("FAIL ge_latency got %0d exp 11", lat); end
      checks++; if ({out3[2], out3[1], out3[0]} !== 24'h000001) begin errors++; $display("FAIL ge_out got %h exp 000001", {out3[2], out3[1], out3[0]}); end
      checks++; if (ge_p3 !== 1'b1) begin errors++; $display("FAIL ge_flag got %b exp 1", ge_p3); end
      checks++; if (wr_cnt !== 3 || gap !== 1'b0) begin errors++; $display("FAIL ge_writes got %0d gap %b exp 3 gap 0", wr_cnt, gap); end
      checks++; if (prd_cnt !== 3 || rrd_cnt !== 4) begin errors++; $display("FAIL ge_reads got p %0d res %0d exp p 3 res 4", prd_cnt, rrd_cnt); end
      checks++; if (busy3 !== 1'b0 || busy_low !== 1'b0) begin errors++; $display("FAIL ge_busy got at_done %b dropped_early %b exp 0 0", busy3, busy_low); end
      @(negedge clk);
      checks++; if ({done3, ge_p3, busy3} !== 3'b010) begin errors++; $display("FAIL ge_after_done got %b exp 010", {done3, ge_p3, busy3}); end
   endtask

   task automatic test_t_lt_p();
      int lat;
      load3(24'h7FFFFE, 8'h00);
      run3(lat);
      checks++; if (lat !== 11) begin errors++; $display("FAIL lt_latency got %0d exp 11", lat); end
      checks++; if ({out3[2], out3[1], out3[0]} !== 24'h7FFFFE) begin errors++; $display("FAIL lt_out got %h exp 7ffffe", {out3[2], out3[1], out3[0]}); end
      checks++; if (ge_p3 !== 1'b0) begin errors++; $display("FAIL lt_flag got %b exp 0", ge_p3); end
   endtask

   task automatic test_t_eq_p_pad();
      int lat;
      load3(24'h7FFFFF, 8'hAA);
      run3(lat);
      checks++; if ({out3[2], out3[1], out3[0]} !== 24'h000000) begin errors++; $display("FAIL eq_out got %h exp 000000", {out3[2], out3[1], out3[0]}); end
      checks++; if (ge_p3 !== 1'b1) begin errors++; $display("FAIL eq_flag got %b exp 1", ge_p3); end
      checks++; if (wr_cnt !== 3) begin errors++; $display("FAIL eq_writes got %0d exp 3", wr_cnt); end
   endtask

   task automatic test_abort_restart();
      int lat, wr_after, done_after;
      bit busy_drop;
      load3(24'h800000, 8'hAA);
      busy_drop = 0; wr_after = 0; done_after = 0;
      @(negedge clk); start3 = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk);
         start3 = (n == 2);
         if (n == 5) rst = 1'b1;
         if (!busy3) busy_drop = 1;
      end
      @(negedge clk);
      checks++; if (busy_drop !== 1'b0) begin errors++; $display("FAIL abort_busy_before got dropped %b exp 0", busy_drop); end
      checks++; if ({busy3, res_rd_en3, p_rd_en3, out_wr_en3} !== 4'b0000) begin errors++; $display("FAIL abort_idle got %b exp 0000", {busy3, res_rd_en3, p_rd_en3, out_wr_en3}); end
      rst = 1'b0;
      for (int n = 0; n < 30; n++) begin
         if (out_wr_en3) wr_after++;
         if (done3) done_after++;
         @(negedge clk);
      end
      checks++; if (wr_after !== 0 || done_after !== 0) begin errors++; $display("FAIL abort_quiet got writes %0d done %0d exp 0 0", wr_after, done_after); end
      load3(24'h900001, 8'hAA);
      run3(lat);
      checks++; if (lat !== 11) begin errors++; $display("FAIL restart_latency got %0d exp 11", lat); end
      checks++; if ({out3[2], out3[1], out3[0]} !== 24'h100002) begin errors++; $display("FAIL restart_out got %h exp 100002", {out3[2], out3[1], out3[0]}); end
      checks++; if (ge_p3 !== 1'b1) begin errors++; $display("FAIL restart_flag got %b exp 1", ge_p3); end
   endtask

   task automatic test_even_width();
      int lat;
      load4(32'hFFFFFFFE, 32'hFFFFFFFD);
      run4(lat);
      checks++; if (lat !== 13) begin errors++; $display("FAIL even_latency got %0d exp 13", lat); end
      checks++; if ({out4[3], out4[2], out4[1], out4[0]} !== 32'h00000001) begin errors++; $display("FAIL even_out got %h exp 00000001", {out4[3], out4[2], out4[1], out4[0]}); end
      checks++; if (wr_cnt !== 4 || gap !== 1'b0) begin errors++; $display("FAIL even_writes got %0d gap %b exp 4 gap 0", wr_cnt, gap); end
      checks++; if (ge_p4 !== 1'b1) begin errors++; $display("FAIL even_flag got %b exp 1", ge_p4); end
      load4(32'h00000005, 32'hFFFFFFFD);
      run4(lat);
      checks++; if ({out4[3], out4[2], out4[1], out4[0]} !== 32'h00000005) begin errors++; $display("FAIL even_lt_out got %h exp 00000005", {out4[3], out4[2], out4[1], out4[0]}); end
      checks++; if (ge_p4 !== 1'b0) begin errors++; $display("FAIL even_lt_flag got %b exp 0", ge_p4); end
   endtask

`ifdef MONT_NEG_CORRECTION_EN
   task automatic test_neg_fix();
      int lat;
      load3(24'hFFFFFF, 8'h00);
      neg_fix3 = 1'b1;
      run3(lat);
      neg_fix3 = 1'b0;
      checks++; if (lat !== 11) begin errors++; $display("FAIL neg_latency got %0d exp 11", lat); end
      checks++; if ({out3[2], out3[1], out3[0]} !== 24'h7FFFFE) begin errors++; $display("FAIL neg_out got %h exp 7ffffe", {out3[2], out3[1], out3[0]}); end
      checks++; if (ge_p3 !== 1'b1) begin errors++; $display("FAIL neg_flag got %b exp 1", ge_p3); end
   endtask
`endif

   initial begin
      checks = 0; errors = 0;
      rst = 1'b1; start3 = 1'b0; start4 = 1'b0;
`ifdef MONT_NEG_CORRECTION_EN
      neg_fix3 = 1'b0; neg_fix4 = 1'b0;
`endif
      test_reset();
      test_t_ge_p();
      test_t_lt_p();
      test_t_eq_p_pad();
      test_abort_restart();
      test_even_width();
`ifdef MONT_NEG_CORRECTION_EN
      test_neg_fix();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mont_res_final_sub.md
Name: mont_res_final_sub

Overview:
- Downstream stage of the pipelined Montgomery multiplier.
- Reads the multiplier's packed result memory, which holds a value t < 2p, and computes t - p digit-serially with a borrow chain.
- Writes the reduced result (t - p if t >= p, else t) one digit per cycle into the Fp^2 output memory.
- Two passes over the data:
  - Pass 1 computes the difference into a local scratch buffer.
  - Pass 2 selects the result by the final borrow.

Parameters:
- RADIX, 24, bits per digit.
- WIDTH_REAL, 32, number of digits in the operand.
- WIDTH, ((WIDTH_REAL+1)/2)*2, digit count rounded up to even.
- RES_MEM_DEPTH, WIDTH/2, result memory entries (2 digits per entry).
- RES_MEM_DEPTH_LOG, CLOG2(RES_MEM_DEPTH), result memory address width.
- DIGIT_LOG, CLOG2(WIDTH_REAL), digit address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begin operation
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when the last output digit has been written
- res_rd_en  out  1  result memory read enable
- res_rd_addr  out  RES_MEM_DEPTH_LOG  result memory entry address
- res_dout  in  2*RADIX  entry data, 1-cycle read latency; [2R-1:R]=t[2i], [R-1:0]=t[2i+1]
- p_rd_en  out  1  modulus memory read enable
- p_rd_addr  out  DIGIT_LOG  modulus digit address
- p_dout  in  RADIX  modulus digit, 1-cycle latency
- out_wr_en  out  1  output digit write strobe
- out_wr_addr  out  DIGIT_LOG  output digit index, digit 0 = least significant
- out_din  out  RADIX  output digit
- ge_p  out  1  final comparison flag (t >= p), valid from done until the next start

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Scratch contents don't-care.
- FSM states: IDLE -> SUB -> SEL -> FIN -> IDLE.
- IDLE:
  - start moves to SUB, clears the digit counter k and the borrow.
  - start in any other state is ignored.
- SUB:
  - Issue res_rd_addr = k>>1 on even k.
  - Issue p_rd_addr = k every cycle, k = 0..WIDTH_REAL-1.
  - Data arrives 1 cycle later. Digit k = left half if k even, otherwise the right half of the registered entry.
  - Compute {b', d} = t[k] - p[k] - b, as a (RADIX+1)-bit result.
  - Write d to scratch[k]; b <= b'.
  - After the last digit's arithmetic, latch ge_p = ~b and go to SEL.
- Odd WIDTH_REAL: the right half of the final entry is padding and is never consumed.
- SEL:
  - Re-read the result memory with the same addressing as SUB, and read scratch[k].
  - out_din = ge_p ? scratch[k] : t[k].
  - out_wr_en is high for exactly WIDTH_REAL consecutive cycles; out_wr_addr runs 0..WIDTH_REAL-1.
  - p_rd_en is low in SEL.
- FIN: done pulses for one cycle, busy drops in the same cycle, return to IDLE.
- Latency: done is asserted exactly 2*WIDTH_REAL+5 cycles after the start cycle. This is fixed and independent of data.
- Read enables are low outside SUB/SEL, so the result memory port can be arbitrated to other readers when idle.
- Arithmetic:
  - All subtraction is modulo 2^RADIX per digit.
  - Borrow is 1 bit.
  - No result wider than RADIX is written.
- Reset mid-operation:
  - Return to IDLE at the next edge.
  - No further out_wr_en.
  - done is not pulsed.
- start asserted in the same cycle as done (FIN): ignored; the caller re-pulses.

Optional Feature:
- Macro: MONT_NEG_CORRECTION_EN.
- When defined:
  - Add input port neg_fix (1 bit), sampled on start.
  - If neg_fix=1, SUB computes t + p with a carry chain instead, and SEL always outputs scratch (ge_p forced 1).
  - This handles results flagged negative by the subtracting multiplier variant.
  - Latency is unchanged.
- When undefined: no port; behaviour exactly as above.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE/SUB/SEL/FIN).
  - The width formulas for WIDTH and RES_MEM_DEPTH, common with the multiplier.
  - Digit-unpack convention (left half = even digit).
- One sub-module, mont_digit_sub:
  - Registered (RADIX+1)-bit subtract/add slice with borrow/carry in/out and an op-select input.
- Scratch storage reuses the existing single_port_mem.

Test Plan (RADIX=8, WIDTH_REAL=3, entries {t0,t1},{t2,pad}, p=0x7FFFFF):
- t=0x800000 -> out digits 01,00,00 (lsd first); ge_p=1; done at cycle 11 after start.
- t=0x7FFFFE -> out FE,FF,7F unchanged; ge_p=0.
- t=p=0x7FFFFF -> out 00,00,00; ge_p=1. Verify the pad byte 0xAA in entry 1 does not affect the result.
- Second start pulse during SUB plus rst asserted at cycle 5 -> no out_wr_en after reset, done never pulses, busy=0 next cycle. A new start then completes normally with the correct result.
- WIDTH_REAL=4 (even), t=0xFFFFFFFE, p=0xFFFFFFFD -> out 01,00,00,00, 4 writes, done at cycle 13.
- MONT_NEG_CORRECTION_EN, neg_fix=1, t=0xFFFFFF (−1 mod 2^24) -> out FE,FF,7F (t+p mod 2^24); ge_p=1.
